// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and types for the dual-clock FIFO family.
// Read latency of the memory sets the prefetch depth of the output stage.
package fifo_rd_stream_pkg;

    localparam int RD_LAT   = 1;
    localparam int PF_DEPTH = RD_LAT + 1;

    typedef logic [1:0] slot_t;

    function automatic slot_t add_bit(input slot_t a, input logic b);
        return a + {1'b0, b};
    endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf.sv
// Two-entry prefetch buffer with explicit count, so pointer wrap
// never creates a full/empty ambiguity.
module rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [DATASIZE-1:0] wdata_i,
    output logic [DATASIZE-1:0] rdata_o,
    output logic                valid_o,
    output slot_t               count_o
);

    logic [DATASIZE-1:0] mem_q [PF_DEPTH];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    slot_t               count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = add_bit(count_q, push_i) - {1'b0, pop_i};
        if (push_i) wr_ptr_d = ~wr_ptr_q;
        if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; count gates its visibility.
    always_ff @(posedge rclk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side output stage: turns rempty/rinc plus a 1-cycle memory
// read into a registered valid/ready stream via a credit loop.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rempty,
    output logic                rinc,
    input  logic [DATASIZE-1:0] rdata,
    output logic                out_valid,
    output logic [DATASIZE-1:0] out_data,
    input  logic                out_ready,
    output logic [1:0]          occupancy
);

    logic  inflight_q;
    logic  pop;
    slot_t count;
    slot_t slots;

    assign pop   = out_valid && out_ready;
    assign slots = add_bit(count, inflight_q);

    // Reset gating keeps rinc low while the pointer logic is held in reset.
    assign rinc = rrst_n && !rempty
                  && ((slots < slot_t'(PF_DEPTH)) || pop);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) inflight_q <= 1'b0;
        else         inflight_q <= rinc;
    end

    rd_skid_buf #(
        .DATASIZE (DATASIZE)
    ) u_buf (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .wdata_i (rdata),
        .rdata_o (out_data),
        .valid_o (out_valid),
        .count_o (count)
    );

    assign occupancy = slots;

endmodule
